// File: rtl/fdiv_iter.sv
// rtl/fdiv_iter.sv - iterative single-precision divider, restoring division with truncation
module fdiv_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] c,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t             state, state_nx;
  logic               sgn;
  logic signed [9:0]  ed;
  logic [24:0]        rem;
  logic [23:0]        dvs;
  logic [4:0]         cnt;
  logic [24:0]        q;

  logic               accept;
  logic               a_zero, b_zero, s_in;
  logic               ge;
  logic [23:0]        rem_sub;
  logic signed [9:0]  e_n;
  logic [22:0]        mant;
  logic [7:0]         exp_f;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign a_zero    = (a[30:23] == 8'h00);
  assign b_zero    = (b[30:23] == 8'h00);
  assign s_in      = a[31] ^ b[31];

  // Remainder stays below 2^24 after each step, so the shifted value fits in 25 bits.
  assign ge      = (rem >= {1'b0, dvs});
  assign rem_sub = ge ? 24'(rem - {1'b0, dvs}) : rem[23:0];

  assign e_n   = q[24] ? ed : (ed - 10'sd1);
  assign mant  = q[24] ? q[23:1] : q[22:0];
  assign exp_f = (e_n <= 10'sd0)   ? 8'h00 :
                 (e_n >= 10'sd255) ? 8'hFF : e_n[7:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = (a_zero || b_zero) ? DONE : DIV;
      DIV:  if (cnt == 5'd0) state_nx = NORM;
      NORM: state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sgn <= 1'b0;
      ed  <= 10'sd0;
      rem <= 25'd0;
      dvs <= 24'd0;
      cnt <= 5'd0;
      q   <= 25'd0;
      c   <= 32'h0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sgn <= s_in;
          ed  <= $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;
          rem <= {1'b0, 1'b1, a[22:0]};
          dvs <= {1'b1, b[22:0]};
          cnt <= 5'd24;
          q   <= 25'd0;
          // Zero dividend wins over zero divisor.
          if (a_zero)      c <= 32'h0;
          else if (b_zero) c <= {s_in, 8'hFF, 23'h0};
        end
        DIV: begin
          q   <= {q[23:0], ge};
          rem <= {rem_sub, 1'b0};
          cnt <= cnt - 5'd1;
        end
        NORM: c <= {sgn, exp_f, mant};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_iter.sv
// tb/tb_fdiv_iter.sv - randomized self-checking bench for fdiv_iter
module tb_fdiv_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] a = 32'h0, b = 32'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] c;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int          tests = 0;
  int          fails = 0;
  logic        exp_pending = 1'b0;
  logic [31:0] exp_c = 32'h0;

  fdiv_iter dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
    .c(c), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Quotient from real-valued significand ratio, normalized and truncated.
  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y);
    logic       s;
    int         ed, e;
    longint     na, nb, qv;
    logic [63:0] qb;
    logic [22:0] m;
    logic [7:0]  ef;
    s = x[31] ^ y[31];
    if (x[30:23] == 8'h00) return 32'h0;
    if (y[30:23] == 8'h00) return {s, 8'hFF, 23'h0};
    ed = int'(x[30:23]) - int'(y[30:23]) + 127;
    na = 64'h800000 | longint'(x[22:0]);
    nb = 64'h800000 | longint'(y[22:0]);
    qv = (na <<< 24) / nb;
    qb = qv;
    if (qv >= 64'h1000000) begin m = qb[23:1]; e = ed;     end
    else                   begin m = qb[22:0]; e = ed - 1; end
    if (e <= 0)        ef = 8'h00;
    else if (e >= 255) ef = 8'hFF;
    else               ef = e[7:0];
    return {s, ef, m};
  endfunction

  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (!exp_pending) check("spurious_out_valid", 32'(out_valid), 32'd0);
      else begin
        check("c_vs_model", c, exp_c);
        check("in_ready_in_done", 32'(in_ready), 32'd0);
      end
    end
  end

  task automatic do_accept(input logic [31:0] ta, input logic [31:0] tb_);
    logic rdy;
    int   guard;
    a = ta; b = tb_; in_valid = 1'b1;
    guard = 0;
    do begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); guard++;
    end while (!rdy && guard < 20);
    if (!rdy) check("accept_timeout", 32'(rdy), 32'd1);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input int hold,
                        input logic use_lit, input logic [31:0] lit);
    int lat, exp_lat;
    logic [31:0] held;
    exp_lat = (ta[30:23] == 8'h00 || tb_[30:23] == 8'h00) ? 1 : 27;
    out_ready = 1'b0;
    do_accept(ta, tb_);
    exp_c = model(ta, tb_);
    exp_pending = 1'b1;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    if (use_lit) check("c_literal", c, lit);
    held = c;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_c", c, held);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_pending = 1'b0;
    check("post_hs_out_valid", 32'(out_valid), 32'd0);
    check("post_hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  function automatic logic [31:0] rand_fp();
    int r;
    logic [7:0] e;
    r = $urandom_range(0, 15);
    if (r == 0)      e = 8'h00;
    else if (r == 1) e = 8'hFF;
    else if (r == 2) e = 8'(($urandom_range(0, 1) != 0) ? $urandom_range(1, 6) : $urandom_range(249, 254));
    else             e = 8'($urandom_range(1, 254));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  initial begin
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_c", c, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    run_op(32'h40C00000, 32'h40000000, 10, 1'b1, 32'h40400000);
    run_op(32'h3F800000, 32'h40400000, 0, 1'b1, 32'h3EAAAAAA);

    // Reset in the middle of the division
    do_accept(32'h40C00000, 32'h40000000);
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_c", c, 32'h0);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("midreset_held_c", c, 32'h0);
    rst = 1'b1;
    run_op(32'h40C00000, 32'h40000000, 0, 1'b1, 32'h40400000);

    run_op(32'h00000000, 32'hC0000000, 2, 1'b1, 32'h00000000);
    run_op(32'hBF800000, 32'h00000000, 0, 1'b1, 32'hFF800000);
    run_op(32'h7F000000, 32'h00800000, 0, 1'b1, 32'h7F800000);
    run_op(32'h00800000, 32'h7F000000, 0, 1'b1, 32'h00000000);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra, rb;
      ra = rand_fp();
      rb = rand_fp();
      run_op(ra, rb, $urandom_range(0, 2), 1'b0, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
